// File: rtl/mult_share_arb.sv
// -----------------------------------------------------------------------------
// mult_share_arb
//   Shares one pipelined multiplier macro among NUM_REQ requesters in the DDS
//   datapath. Each cycle, one valid requester is granted by round-robin. Its
//   operands are registered into the multiplier. A requester tag travels beside
//   the multiplier pipeline, so each product returns to the requester that
//   issued it as a one-cycle strobe.
//
// Build option:
//   MULT_SHARE_ARB_PRIO0_EN - when defined, requester 0 has absolute priority.
//                             Round-robin then covers requesters 1..NUM_REQ-1
//                             only, and grants to 0 leave the pointer untouched.
//
// Ports:
//   CLK, RST         clock; synchronous active-high reset
//   REQ_VALID        per-requester request
//   REQ_A / REQ_B    packed operands, requester i at [i*W +: W]
//   REQ_READY        one-hot grant (combinational)
//   MUL_A/MUL_B/CE   registered operands and enable towards the multiplier
//   MUL_P            product from the multiplier, LATENCY cycles after sampling
//   RES_VALID        one-hot result strobe
//   RES_ID / RES_P   owner index and unsigned product (held between strobes)
//   BUSY             a product is in flight
// -----------------------------------------------------------------------------
module mult_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16,
    parameter int LATENCY = 3,
    parameter int ID_W    = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           REQ_VALID,
    input  logic [NUM_REQ*WIDTH_A-1:0]   REQ_A,
    input  logic [NUM_REQ*WIDTH_B-1:0]   REQ_B,
    output logic [NUM_REQ-1:0]           REQ_READY,
    output logic [WIDTH_A-1:0]           MUL_A,
    output logic [WIDTH_B-1:0]           MUL_B,
    output logic                         MUL_CE,
    input  logic [WIDTH_A+WIDTH_B-1:0]   MUL_P,
    output logic [NUM_REQ-1:0]           RES_VALID,
    output logic [ID_W-1:0]              RES_ID,
    output logic [WIDTH_A+WIDTH_B-1:0]   RES_P,
    output logic                         BUSY
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [ID_W-1:0]    last_r;
    logic [ID_W-1:0]    issue_id_r;
    logic [ID_W-1:0]    grant_id_s;
    logic               grant_hit_s;
    logic [WIDTH_A-1:0] sel_a_s;
    logic [WIDTH_B-1:0] sel_b_s;
    logic [LATENCY-1:0] tag_valid_r;
    logic [ID_W-1:0]    tag_id_r [LATENCY];
    int                 rr_dist_s;
    int                 best_dist_s;

    // Round-robin arbiter. Each requester's distance from LAST+1, with
    // wrap-around, gives its place in the search order. The closest valid
    // requester wins.
    always_comb begin
        grant_hit_s = 1'b0;
        grant_id_s  = '0;
        best_dist_s = NUM_REQ;
        rr_dist_s   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_dist_s = i - int'(last_r) - 32'sd1;
            if (rr_dist_s < 0) begin
                rr_dist_s = rr_dist_s + NUM_REQ;
            end else begin
                rr_dist_s = rr_dist_s;
            end
`ifdef MULT_SHARE_ARB_PRIO0_EN
            if ((i != 0) && REQ_VALID[i] && (rr_dist_s < best_dist_s)) begin
`else
            if (REQ_VALID[i] && (rr_dist_s < best_dist_s)) begin
`endif
                best_dist_s = rr_dist_s;
                grant_hit_s = 1'b1;
                grant_id_s  = ID_W'(i);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
`ifdef MULT_SHARE_ARB_PRIO0_EN
        // The phase path overrides the rotating search.
        if (REQ_VALID[0]) begin
            grant_hit_s = 1'b1;
            grant_id_s  = '0;
        end else begin
            grant_hit_s = grant_hit_s;
        end
`endif
        if (RST) begin
            grant_hit_s = 1'b0;
            grant_id_s  = '0;
        end else begin
            grant_hit_s = grant_hit_s;
        end
        if (grant_hit_s) begin
            REQ_READY = ONE_HOT0 << grant_id_s;
        end else begin
            REQ_READY = '0;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_s == ID_W'(i)) begin
                sel_a_s = REQ_A[i*WIDTH_A +: WIDTH_A];
                sel_b_s = REQ_B[i*WIDTH_B +: WIDTH_B];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // Issue stage: register the winner's operands and update the pointer.
    // On idle cycles the operands hold and only CE drops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MUL_A      <= '0;
            MUL_B      <= '0;
            MUL_CE     <= 1'b0;
            issue_id_r <= '0;
            last_r     <= ID_W'(NUM_REQ - 1);
        end else if (grant_hit_s) begin
            MUL_A      <= sel_a_s;
            MUL_B      <= sel_b_s;
            MUL_CE     <= 1'b1;
            issue_id_r <= grant_id_s;
`ifdef MULT_SHARE_ARB_PRIO0_EN
            if (grant_id_s != '0) begin
                last_r <= grant_id_s;
            end else begin
                last_r <= last_r;
            end
`else
            last_r     <= grant_id_s;
`endif
        end else begin
            MUL_CE     <= 1'b0;
        end
    end

    // Tag pipeline. It shifts every cycle, so its last stage lines up with
    // MUL_P for the operands that CE sampled LATENCY cycles earlier.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_valid_r <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_id_r[k] <= '0;
            end
        end else begin
            tag_valid_r[0] <= MUL_CE;
            tag_id_r[0]    <= issue_id_r;
            for (int k = 1; k < LATENCY; k++) begin
                tag_valid_r[k] <= tag_valid_r[k-1];
                tag_id_r[k]    <= tag_id_r[k-1];
            end
        end
    end

    // Return stage. It captures the product only when the tag says it is
    // real, so stale MUL_P is never forwarded.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RES_VALID <= '0;
            RES_ID    <= '0;
            RES_P     <= '0;
        end else if (tag_valid_r[LATENCY-1]) begin
            RES_VALID <= ONE_HOT0 << tag_id_r[LATENCY-1];
            RES_ID    <= tag_id_r[LATENCY-1];
            RES_P     <= MUL_P;
        end else begin
            RES_VALID <= '0;
        end
    end

    // Busy while an operand is on the multiplier inputs or any tag is live.
    always_comb begin
        BUSY = (|tag_valid_r) | MUL_CE;
    end

endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;

    localparam int N       = 4;
    localparam int WA      = 16;
    localparam int WB      = 16;
    localparam int LAT     = 3;
    localparam int IDW     = 2;
    localparam int PW      = WA + WB;
    localparam int RES_LAT = LAT + 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N-1:0]    REQ_VALID;
    logic [N*WA-1:0] REQ_A;
    logic [N*WB-1:0] REQ_B;
    logic [N-1:0]    REQ_READY;
    logic [WA-1:0]   MUL_A;
    logic [WB-1:0]   MUL_B;
    logic            MUL_CE;
    logic [PW-1:0]   MUL_P;
    logic [N-1:0]    RES_VALID;
    logic [IDW-1:0]  RES_ID;
    logic [PW-1:0]   RES_P;
    logic            BUSY;

    always #5 CLK = ~CLK;

    mult_share_arb #(.NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .LATENCY(LAT), .ID_W(IDW)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_B(REQ_B),
        .REQ_READY(REQ_READY), .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_CE(MUL_CE), .MUL_P(MUL_P),
        .RES_VALID(RES_VALID), .RES_ID(RES_ID), .RES_P(RES_P), .BUSY(BUSY)
    );

    // Multiplier macro model: free-running pipeline, product valid LAT cycles after sampling.
    logic [PW-1:0] p_pipe [LAT];
    initial for (int k = 0; k < LAT; k++) p_pipe[k] = '0;
    always @(posedge CLK) begin
        p_pipe[0] <= PW'(MUL_A) * PW'(MUL_B);
        for (int k = 1; k < LAT; k++) p_pipe[k] <= p_pipe[k-1];
    end
    assign MUL_P = p_pipe[LAT-1];

    // Reference model state.
    typedef struct { int due; int id; logic [PW-1:0] p; } exp_t;
    exp_t exp_q[$];
    int vectors = 0, miscompares = 0, cyc = 0;
    int m_last = N - 1, m_grant = -1, obs_grant = -1;
    logic [PW-1:0] held_p = '0;
    int held_id = 0;
    logic [WA-1:0] a_arr [N];
    logic [WB-1:0] b_arr [N];
    logic [N-1:0]  vld;
    int seen_cnt = 0, seen_id = 0, seen_at = 0;
    logic [PW-1:0] seen_p = '0;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            REQ_A[i*WA +: WA] = a_arr[i];
            REQ_B[i*WB +: WB] = b_arr[i];
        end
        REQ_VALID = vld;
    endtask

    function automatic int pick(logic [N-1:0] v);
        int idx;
`ifdef MULT_SHARE_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
`ifdef MULT_SHARE_ARB_PRIO0_EN
            if (idx == 0) continue;
`endif
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle: check outputs at the falling edge, advance the model, step past the rising edge.
    task automatic step();
        exp_t e;
        logic [N-1:0] exp_rv, exp_rdy;
        logic exp_busy;
        @(negedge CLK);
        exp_rv = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            exp_rv[e.id] = 1'b1;
            held_p = e.p;
            held_id = e.id;
        end
        exp_busy = 1'b0;
        foreach (exp_q[k]) if (exp_q[k].due - cyc <= LAT + 1) exp_busy = 1'b1;
        vectors++;
        if (RES_VALID !== exp_rv) begin
            miscompares++; $display("FAIL res_valid cyc=%0d got=%b exp=%b", cyc, RES_VALID, exp_rv);
        end
        vectors++;
        if (RES_ID !== IDW'(held_id)) begin
            miscompares++; $display("FAIL res_id cyc=%0d got=%0d exp=%0d", cyc, RES_ID, held_id);
        end
        vectors++;
        if (RES_P !== held_p) begin
            miscompares++; $display("FAIL res_p cyc=%0d got=%h exp=%h", cyc, RES_P, held_p);
        end
        vectors++;
        if (BUSY !== exp_busy) begin
            miscompares++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, BUSY, exp_busy);
        end
        if (RES_VALID != '0) begin
            seen_cnt++; seen_p = RES_P; seen_id = int'(RES_ID); seen_at = cyc;
        end
        obs_grant = -1;
        for (int i = 0; i < N; i++) if (REQ_READY[i] === 1'b1) obs_grant = i;
        m_grant = RST ? -1 : pick(vld);
        exp_rdy = '0;
        if (m_grant >= 0) exp_rdy[m_grant] = 1'b1;
        vectors++;
        if (REQ_READY !== exp_rdy) begin
            miscompares++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, REQ_READY, exp_rdy);
        end
        if (RST) begin
            exp_q.delete();
            m_last = N - 1;
            held_p = '0;
            held_id = 0;
        end else if (m_grant >= 0) begin
            e.due = cyc + RES_LAT;
            e.id  = m_grant;
            e.p   = PW'(a_arr[m_grant]) * PW'(b_arr[m_grant]);
            exp_q.push_back(e);
`ifdef MULT_SHARE_ARB_PRIO0_EN
            if (m_grant != 0) m_last = m_grant;
`else
            m_last = m_grant;
`endif
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; vld = '0; drive(); step();
        RST = 1'b0; drive();
    endtask

    task automatic drain();
        vld = '0; drive();
        repeat (RES_LAT + 2) step();
    endtask

    task automatic test_reset();
        vld = '1; drive();
        step();
        vectors++;
        if (MUL_CE !== 1'b0 || MUL_A !== '0 || MUL_B !== '0) begin
            miscompares++; $display("FAIL reset_mul got ce=%b a=%h b=%h exp 0/0/0", MUL_CE, MUL_A, MUL_B);
        end
        RST = 1'b0; vld = '0; drive();
        step();
    endtask

    task automatic test_single();
        int start;
        do_reset();
        seen_cnt = 0;
        vld = 4'b0001; a_arr[0] = 16'd3; b_arr[0] = 16'd5; drive();
        start = cyc;
        step();
        vectors++;
        if (obs_grant !== 0) begin
            miscompares++; $display("FAIL single_grant got=%0d exp=0", obs_grant);
        end
        drain();
        vectors++;
        if (seen_cnt !== 1 || seen_p !== 32'd15 || seen_id !== 0 || seen_at !== start + 5) begin
            miscompares++;
            $display("FAIL single_result got cnt=%0d p=%0d id=%0d at=%0d exp 1/15/0/%0d",
                     seen_cnt, seen_p, seen_id, seen_at, start + 5);
        end
    endtask

    task automatic test_back_to_back();
        int exp_g;
        do_reset();
        seen_cnt = 0;
        vld = 4'b1111;
        for (int i = 0; i < N; i++) begin a_arr[i] = WA'(i + 1); b_arr[i] = 16'd100; end
        drive();
        for (int k = 0; k < 8; k++) begin
            step();
`ifdef MULT_SHARE_ARB_PRIO0_EN
            exp_g = 0;
`else
            exp_g = k % N;
`endif
            vectors++;
            if (obs_grant !== exp_g) begin
                miscompares++; $display("FAIL rotate_grant k=%0d got=%0d exp=%0d", k, obs_grant, exp_g);
            end
        end
        drain();
        vectors++;
        if (seen_cnt !== 8) begin
            miscompares++; $display("FAIL rotate_count got=%0d exp=8", seen_cnt);
        end
    endtask

    task automatic test_max_operands();
        vld = 4'b0100; a_arr[2] = 16'hFFFF; b_arr[2] = 16'hFFFF; drive();
        step();
        drain();
        vectors++;
        if (seen_p !== 32'hFFFE0001 || seen_id !== 2) begin
            miscompares++; $display("FAIL max_product got p=%h id=%0d exp p=fffe0001 id=2", seen_p, seen_id);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        vld = 4'b0111;
        for (int i = 0; i < N; i++) begin a_arr[i] = WA'(7 + i); b_arr[i] = WB'(11 + i); end
        drive();
        step(); step();
        RST = 1'b1; drive(); step();
        RST = 1'b0; vld = '0; drive();
        seen_cnt = 0;
        repeat (RES_LAT + 3) step();
        vectors++;
        if (seen_cnt !== 0) begin
            miscompares++; $display("FAIL reset_mid_results got=%0d exp=0", seen_cnt);
        end
        vld = 4'b1111; drive();
        step();
        vectors++;
        if (obs_grant !== 0) begin
            miscompares++; $display("FAIL reset_mid_grant got=%0d exp=0", obs_grant);
        end
        drain();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < N; i++) begin a_arr[i] = WA'(i + 20); b_arr[i] = WB'(i + 3); end
        vld = 4'b0010; drive(); step();
        vld = 4'b0110; drive(); step();
        vectors++;
        if (obs_grant !== 2) begin
            miscompares++; $display("FAIL wrap_first got=%0d exp=2", obs_grant);
        end
        vld = 4'b0010; drive(); step();
        vectors++;
        if (obs_grant !== 1) begin
            miscompares++; $display("FAIL wrap_second got=%0d exp=1", obs_grant);
        end
        vld = '0; drive(); step(); step();
        vld = 4'b0110; drive(); step();
        vectors++;
        if (obs_grant !== 2) begin
            miscompares++; $display("FAIL wrap_after_idle got=%0d exp=2", obs_grant);
        end
        drain();
    endtask

`ifdef MULT_SHARE_ARB_PRIO0_EN
    task automatic test_prio0();
        do_reset();
        for (int i = 0; i < N; i++) begin a_arr[i] = WA'(i + 2); b_arr[i] = WB'(9); end
        vld = 4'b1111; drive();
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if (obs_grant !== 0) begin
                miscompares++; $display("FAIL prio0_win k=%0d got=%0d exp=0", k, obs_grant);
            end
        end
        vld = 4'b1110; drive();
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if (obs_grant !== (k % 3) + 1) begin
                miscompares++; $display("FAIL prio0_rr k=%0d got=%0d exp=%0d", k, obs_grant, (k % 3) + 1);
            end
        end
        drain();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (vld[i] && m_grant != i && $urandom_range(0, 7) != 0) begin
                    vld[i] = 1'b1;
                end else begin
                    vld[i]   = ($urandom_range(0, 3) != 0);
                    a_arr[i] = WA'($urandom);
                    b_arr[i] = WB'($urandom);
                end
            end
            RST = ($urandom_range(0, 49) == 0);
            drive();
            step();
        end
        RST = 1'b0;
        drain();
    endtask

    initial begin
        vld = '0;
        for (int i = 0; i < N; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
        drive();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_max_operands();
        test_reset_mid();
        test_wrap();
`ifdef MULT_SHARE_ARB_PRIO0_EN
        test_prio0();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one pipelined multiplier macro (registered product, fixed pipeline latency) among NUM_REQ requesters in the DDS datapath, e.g. amplitude scaling and phase-offset correction.
- Grants one requester per cycle by round-robin and registers the selected operands into the multiplier.
- Tracks a requester tag alongside the multiplier pipeline and returns each product to its originator with a one-cycle valid pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH_A, 16, operand A width
- WIDTH_B, 16, operand B width
- LATENCY, 3, multiplier cycles from MUL_A/MUL_B/MUL_CE sampled to MUL_P valid; must match the attached multiplier
- ID_W, 2, tag width, ceil(log2(NUM_REQ)), minimum 1

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- REQ_VALID  in  NUM_REQ  per-requester request
- REQ_A  in  NUM_REQ*WIDTH_A  packed operand A; requester i at bits [i*WIDTH_A +: WIDTH_A]
- REQ_B  in  NUM_REQ*WIDTH_B  packed operand B, same packing
- REQ_READY  out  NUM_REQ  one-hot grant; combinational
- MUL_A  out  WIDTH_A  to multiplier A
- MUL_B  out  WIDTH_B  to multiplier B
- MUL_CE  out  1  to multiplier CE
- MUL_P  in  WIDTH_A+WIDTH_B  from multiplier P
- RES_VALID  out  NUM_REQ  one-hot result strobe
- RES_ID  out  ID_W  index of the result owner
- RES_P  out  WIDTH_A+WIDTH_B  product, unsigned
- BUSY  out  1  high while any product is in flight

Behaviour:
- Arbitration
  - Round-robin pointer LAST holds the index of the last granted requester.
  - Search order: LAST+1, LAST+2, ... with wrap modulo NUM_REQ.
  - REQ_READY[i]=1 only for the first valid requester in that order. All zeros if no REQ_VALID or RST=1.
  - A transfer occurs when REQ_VALID[i] & REQ_READY[i] in cycle t. LAST<=i at the edge. LAST is unchanged on idle cycles.
- Issue
  - At the edge ending cycle t: MUL_A<=REQ_A[i], MUL_B<=REQ_B[i], MUL_CE<=1.
  - Idle cycle: MUL_CE<=0 and MUL_A/MUL_B hold.
- Tag pipeline
  - Shift register of depth LATENCY, each entry {valid, id}. Stage 0 loads {MUL_CE, issued id}; it advances every cycle, independent of MUL_CE.
  - Stage LATENCY-1 valid aligns with MUL_P valid.
- Return
  - When the last tag stage is valid: RES_P<=MUL_P, RES_ID<=id, RES_VALID<=one-hot(id) for exactly one cycle.
  - Otherwise RES_VALID<=0, and RES_P/RES_ID hold.
  - Total latency from accept (cycle t) to RES_VALID: LATENCY+2 cycles (5 at default).
  - Throughput: one product per cycle, results in issue order.
- BUSY = OR of all tag-stage valids, OR MUL_CE.
- Reset (RST=1)
  - LAST<=NUM_REQ-1, so requester 0 is first after reset.
  - MUL_A/MUL_B<=0, MUL_CE<=0; all tag valids <=0.
  - RES_VALID<=0, RES_ID<=0, RES_P<=0; BUSY=0 from the next cycle.
- Reset mid-operation: in-flight products are discarded and no RES_VALID is emitted for them.
- Boundaries
  - Requester deasserting REQ_VALID before a grant: legal, nothing issued.
  - REQ_A/REQ_B must stay stable while REQ_VALID=1 and not granted.
  - All requesters continuously valid: grants rotate 0,1,2,3,0,... with no gaps.
  - Single requester: granted every cycle.
  - Stale MUL_P while MUL_CE=0 is ignored because the tag is invalid.
  - No backpressure on results: consumers must accept RES_VALID when it is asserted.

Optional Feature:
- Macro: MULT_SHARE_ARB_PRIO0_EN
- Defined: requester 0 has fixed absolute priority (DDS phase path).
  - REQ_VALID[0]=1 always wins.
  - Round-robin applies only among requesters 1..NUM_REQ-1. Grants to 0 do not update LAST.
- Undefined: plain round-robin over all requesters as described above.

Test Plan:
- Reset, then REQ_VALID=0001, A=3, B=5 at cycle 0 -> REQ_READY=0001 at cycle 0; RES_VALID=0001, RES_ID=0, RES_P=15 at cycle 5; BUSY low after cycle 5.
- REQ_VALID=1111 held 8 cycles, A_i=i+1, B_i=100 -> grant order 0,1,2,3,0,1,2,3; RES_P sequence 100,200,300,400,100,... back-to-back starting cycle 5.
- Requester 2 alone, A=16'hFFFF, B=16'hFFFF -> RES_P=32'hFFFE0001, RES_ID=2.
- Three requests issued, RST pulsed for 1 cycle at cycle 2 -> no RES_VALID ever; LAST reset so the next grant goes to 0 if valid.
- REQ_VALID 0110 with LAST=1 -> grant 2, then 1 -> wrap verified; idle gap leaves LAST unchanged.
- With MULT_SHARE_ARB_PRIO0_EN defined, REQ_VALID=1111 constant -> requester 0 granted every cycle and others starve; drop REQ_VALID[0] -> grants 1,2,3 round-robin.
